// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID-stage control decode, ARM condition gating and
// the registered ID/EX control slice with stall/flush.
// Optional multi-cycle multiply sequencer enabled by defining CTRL_MUL_EN.
// Without it, mode 11 always loads a bubble and busy is tied low.
module pipelined_control_unit #(
  parameter int         CMD_W   = 4,
  parameter int         MUL_LAT = 3,
  parameter logic [3:0] MUL_CMD = 4'b1010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s_in,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             branch,
  output logic             s_out,
  output logic             valid_out,
  output logic             busy
);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             mr;
    logic             mw;
    logic             wb;
    logic             br;
    logic             s;
    logic             v;
  } slice_t;

  slice_t     slice;
  slice_t     dec;
  logic [3:0] d_cmd;
  logic       cond_ok;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = status;

  // Evaluate the ARM condition field against the current flags
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = !flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = !flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = !flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = !flag_v;
      4'b1000: cond_ok = flag_c && !flag_z;
      4'b1001: cond_ok = !flag_c || flag_z;
      4'b1010: cond_ok = (flag_n == flag_v);
      4'b1011: cond_ok = (flag_n != flag_v);
      4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ok = flag_z || (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Decode mode/opcode/S into the next control slice; bubble when not live
  always_comb begin
    dec   = '0;
    d_cmd = 4'b0000;
    case (mode)
      2'b00: begin
        dec.wb = 1'b1;
        dec.s  = s_in;
        case (opcode)
          4'b1101: d_cmd = 4'b0001;
          4'b1111: d_cmd = 4'b1001;
          4'b0100: d_cmd = 4'b0010;
          4'b0101: d_cmd = 4'b0011;
          4'b0010: d_cmd = 4'b0100;
          4'b0110: d_cmd = 4'b0101;
          4'b0000: d_cmd = 4'b0110;
          4'b1100: d_cmd = 4'b0111;
          4'b0001: d_cmd = 4'b1000;
          4'b1010: begin d_cmd = 4'b0100; dec.wb = 1'b0; end
          4'b1000: begin d_cmd = 4'b0110; dec.wb = 1'b0; end
          default: begin d_cmd = 4'b0000; dec.wb = 1'b0; dec.s = 1'b0; end
        endcase
      end
      2'b01: begin
        d_cmd  = 4'b0010;
        dec.mr = s_in;
        dec.wb = s_in;
        dec.mw = !s_in;
      end
      2'b10: dec.br = 1'b1;
      default: d_cmd = 4'b0000;
    endcase
    dec.cmd = CMD_W'(d_cmd);
    dec.v   = 1'b1;
    // mode 11 is never a live single-cycle instruction
    if (!(valid_in && cond_ok) || mode == 2'b11) dec = '0;
  end

`ifdef CTRL_MUL_EN
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mul_s;
  logic             mul_accept;
  slice_t           mul_slice;

  assign mul_accept = valid_in && (mode == 2'b11) && cond_ok;

  always_comb begin
    mul_slice     = '0;
    mul_slice.cmd = CMD_W'(MUL_CMD);
    mul_slice.wb  = 1'b1;
    mul_slice.s   = mul_s;
    mul_slice.v   = 1'b1;
  end

  // Slice register plus multiply sequencer: rst > flush > stall > busy > accept > decode
  always_ff @(posedge clk) begin
    if (!rst) begin
      slice <= '0;
      state <= IDLE;
      cnt   <= '0;
      mul_s <= 1'b0;
    end else if (flush) begin
      slice <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else if (stall) begin
      slice <= slice;
    end else if (state == MUL_BUSY) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        slice <= mul_slice;
        state <= IDLE;
      end
    end else if (mul_accept) begin
      slice <= '0;
      state <= MUL_BUSY;
      cnt   <= CNT_W'(MUL_LAT - 1);
      mul_s <= s_in;
    end else begin
      slice <= dec;
    end
  end

  assign busy = (state == MUL_BUSY);
`else
  logic unused_mul_cfg;
  assign unused_mul_cfg = ^{MUL_CMD, MUL_LAT};

  // Slice register: rst > flush (bubble) > stall (hold) > load decode
  always_ff @(posedge clk) begin
    if (!rst)       slice <= '0;
    else if (flush) slice <= '0;
    else if (stall) slice <= slice;
    else            slice <= dec;
  end

  assign busy = 1'b0;
`endif

  assign exe_cmd   = slice.cmd;
  assign mem_read  = slice.mr;
  assign mem_write = slice.mw;
  assign wb_en     = slice.wb;
  assign branch    = slice.br;
  assign s_out     = slice.s;
  assign valid_out = slice.v;

endmodule
